// File: rtl/spi_resp16.sv
// SPI mode-0 responder with oversampled pins: shifts a command in on MOSI
// while returning the buffered response word on MISO, all in the clk domain.
module spi_resp16 #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt_tx,
  output logic [WIDTH-1:0] cmd_rcvd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             frm_err
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, nxt_state;
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [WIDTH-1:0]       tx_buf;
  logic [WIDTH-1:0]       shft;
  logic [WIDTH-1:0]       shft_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   mosi_smpl;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                   mosi_cur;
  logic                   load, smpl, shift, done, good;

  // Bit counter saturates so an overlong frame can never alias to a good count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Synchronizer chains; the top bit of sclk/ss is the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign sclk_rise = ~sclk_sync[SYNC_STAGES] &  sclk_sync[SYNC_STAGES-1];
  assign sclk_fall =  sclk_sync[SYNC_STAGES] & ~sclk_sync[SYNC_STAGES-1];
  assign ss_fall   =  ss_sync[SYNC_STAGES]   & ~ss_sync[SYNC_STAGES-1];
  assign ss_rise   = ~ss_sync[SYNC_STAGES]   &  ss_sync[SYNC_STAGES-1];
  assign mosi_cur  = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    smpl      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          load      = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        smpl  = sclk_rise;
        shift = sclk_fall;
        if (ss_rise) begin
          done      = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // A fall coinciding with ss_rise is folded in before the count check.
  assign shft_nxt = shift ? {shft[WIDTH-2:0], mosi_smpl} : shft;
  assign cnt_nxt  = shift ? sat_inc(bit_cnt) : bit_cnt;
  assign good     = done && (cnt_nxt == FRAME_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf    <= '0;
      shft      <= '0;
      bit_cnt   <= '0;
      mosi_smpl <= 1'b0;
      cmd_rcvd  <= '0;
      cmd_rdy   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      if (wrt_tx && state == IDLE) tx_buf <= tx_data;
      if (load) begin
        shft    <= tx_buf;
        bit_cnt <= '0;
      end else begin
        shft    <= shft_nxt;
        bit_cnt <= cnt_nxt;
      end
      if (smpl) mosi_smpl <= mosi_cur;
      if (good) begin
        cmd_rcvd <= shft_nxt;
        frm_err  <= 1'b0;
      end else if (done) begin
        frm_err  <= 1'b1;
      end
      if (good)             cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

  assign MISO = SS_n ? 1'bz : shft[WIDTH-1];

endmodule

// File: tb/tb_spi_resp16.sv
// Bench for spi_resp16: behavioural SPI master plus a command scoreboard.
module tb_spi_resp16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic [15:0] tx_data = '0;
  logic        wrt_tx = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd_rcvd;
  logic        cmd_rdy;
  logic        frm_err;
  wire         miso_w;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_cmd = '0;
  logic        rdy_prev = 1'b0;

  pullup (miso_w);

  spi_resp16 #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SCLK        (SCLK),
    .SS_n        (SS_n),
    .MOSI        (MOSI),
    .MISO        (miso_w),
    .tx_data     (tx_data),
    .wrt_tx      (wrt_tx),
    .cmd_rcvd    (cmd_rcvd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every newly raised cmd_rdy must deliver the next queued command.
  always @(negedge clk) begin
    if (cmd_rdy && !rdy_prev) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(cmd_rcvd), 32'hFFFF_FFFF);
      else                   chk("sb_cmd", 32'(cmd_rcvd), 32'(exp_q.pop_front()));
    end
    rdy_prev <= cmd_rdy;
  end

  task automatic write_tx(input logic [15:0] d);
    @(negedge clk);
    tx_data = d;
    wrt_tx  = 1'b1;
    @(negedge clk);
    wrt_tx  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clr_rdy", 32'(cmd_rdy), 32'd0);
  endtask

  task automatic spi_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           input logic [15:0] exp_tx, input logic mid_wr, input logic clr_end);
    logic [15:0] resp;
    logic        good;
    resp = '0;
    good = (nbits == 16);
    if (good) exp_q.push_back(cmd);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = cmd[15-i];
      repeat (5) @(negedge clk);
      resp = {resp[14:0], miso_w};
      SCLK = 1'b1;
      if (mid_wr && i == 4) begin
        tx_data = 16'hBEEF;
        wrt_tx  = 1'b1;
        @(negedge clk);
        wrt_tx  = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      SCLK = 1'b0;
    end
    repeat (5) @(negedge clk);
    SS_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_cmd_rdy = clr_end;
    @(posedge clk);
    #1;
    if (good) begin
      chk({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
      chk({tag, "_cmd"}, 32'(cmd_rcvd), 32'(cmd));
      chk({tag, "_err"}, 32'(frm_err), 32'd0);
      last_cmd = cmd;
    end else begin
      chk({tag, "_err"}, 32'(frm_err), 32'd1);
      chk({tag, "_rdy"}, 32'(cmd_rdy), 32'd0);
      chk({tag, "_keep"}, 32'(cmd_rcvd), 32'(last_cmd));
    end
    chk({tag, "_resp"}, 32'(resp), 32'(exp_tx >> (16 - nbits)));
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(cmd_rcvd), 32'd0);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_err", 32'(frm_err), 32'd0);
    chk("rst_miso_z", 32'(miso_w), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    write_tx(16'h1234);
    spi_frame("f1", 16'hA5C3, 16, 16'h1234, 1'b0, 1'b0);
    pulse_clr();

    spi_frame("b2b0", 16'h0001, 16, 16'h1234, 1'b0, 1'b0);
    pulse_clr();
    spi_frame("b2b1", 16'h8000, 16, 16'h1234, 1'b0, 1'b0);
    pulse_clr();

    spi_frame("short", 16'hFF00, 8, 16'h1234, 1'b0, 1'b0);
    spi_frame("good_after", 16'h5555, 16, 16'h1234, 1'b0, 1'b0);
    pulse_clr();

    spi_frame("midwr", 16'h3C3C, 16, 16'h1234, 1'b1, 1'b0);
    pulse_clr();
    write_tx(16'hBEEF);
    spi_frame("idlewr", 16'h1111, 16, 16'hBEEF, 1'b0, 1'b0);
    pulse_clr();

    spi_frame("setwins", 16'h7E81, 16, 16'hBEEF, 1'b0, 1'b1);

    // Abort a frame after 5 bits with reset while cmd_rdy is still set.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      MOSI = i[0];
      repeat (5) @(negedge clk);
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_miso", 32'(miso_w), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", 32'(cmd_rcvd), 32'd0);
    chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("mid_rst_err", 32'(frm_err), 32'd0);
    chk("mid_rst_miso", 32'(miso_w), 32'd0);
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    #1;
    chk("mid_rst_miso_z", 32'(miso_w), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_cmd = '0;
    repeat (4) @(negedge clk);
    spi_frame("post_rst", 16'h0F0F, 16, 16'h0000, 1'b0, 1'b0);
    pulse_clr();

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
